// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative HI/LO multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned ITER = 32;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_seq_addsub33.sv
// 33-bit adder/subtractor. co is the carry for an add and the borrow (a < b) for a subtract.
module addsub33 (
    input  logic [32:0] a,
    input  logic [32:0] b,
    input  logic        sub,
    output logic [32:0] y,
    output logic        co
);

    logic [33:0] full;

    always_comb begin
        full = {1'b0, a} + {1'b0, b ^ {33{sub}}} + {33'd0, sub};
        y    = full[32:0];
        co   = full[33] ^ sub;
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU sequencer holding the architectural HI/LO registers.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic             cancel,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               in_signed;
    logic               in_div;
    logic               run_div;
    logic [CNT_W-1:0]   div_idx;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     as_a;
    logic [WIDTH:0]     as_b;
    logic [WIDTH:0]     as_y;
    logic               as_co;
    logic [2*WIDTH-1:0] acc_neg;
    logic [WIDTH-1:0]   rem_neg;

    assign in_signed = (op == OP_MULT) || (op == OP_DIV);
    assign in_div    = (op == OP_DIVU) || (op == OP_DIV);
    assign run_div   = !((op_q == OP_MULTU) || (op_q == OP_MULT));

    // Dividend bits enter MSB first while the partial remainder shifts left.
    assign div_idx   = CNT_W'(WIDTH - 1) - count_q;
    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], a_q[div_idx]};

    assign as_a = run_div ? div_shift : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    assign as_b = run_div ? {1'b0, b_q} : {1'b0, a_q};

    addsub33 u_addsub (
        .a   (as_a),
        .b   (as_b),
        .sub (run_div),
        .y   (as_y),
        .co  (as_co)
    );

    // The low half of the 64-bit negation doubles as the negated quotient.
    assign acc_neg = '0 - acc_q;
    assign rem_neg = '0 - acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        count_d   = count_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d      = op;
                    a_d       = (in_signed && rs[WIDTH-1]) ? ('0 - rs) : rs;
                    b_d       = (in_signed && rt[WIDTH-1]) ? ('0 - rt) : rt;
                    neg_res_d = in_signed && (rs[WIDTH-1] ^ rt[WIDTH-1]);
                    neg_rem_d = in_signed && in_div && rs[WIDTH-1];
                    dz_d      = in_div && (rt == '0);
                    acc_d     = '0;
                    count_d   = '0;
                    busy_d    = 1'b1;
                    state_d   = ST_RUN;
                end else begin
                    if (mthi) hi_d = wdata;
                    if (mtlo) lo_d = wdata;
                end
            end

            ST_RUN: begin
                if (cancel) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    if (run_div) begin
                        if (as_co)
                            acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                        else
                            acc_d = {as_y[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        if (b_q[count_q])
                            acc_d = {as_y, acc_q[WIDTH-1:1]};
                        else
                            acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
                    end
                    count_d = count_q + 1'b1;
                    if (count_q == CNT_W'(ITER - 1))
                        state_d = ST_FIX;
                end
            end

            ST_FIX: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
                if (!cancel) begin
                    done_d = 1'b1;
                    if (run_div) begin
                        hi_d = neg_rem_q ? rem_neg : acc_q[2*WIDTH-1:WIDTH];
                        if (dz_q)
                            lo_d = '1;
                        else
                            lo_d = neg_res_q ? acc_neg[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    end else begin
                        {hi_d, lo_d} = neg_res_q ? acc_neg : acc_q;
                    end
                end
            end

            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: stimulus pushes reference results, a monitor pops them on done.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        start  = 1'b0;
    logic [1:0]  op     = '0;
    logic [31:0] rs     = '0;
    logic [31:0] rt     = '0;
    logic        cancel = 1'b0;
    logic        mthi   = 1'b0;
    logic        mtlo   = 1'b0;
    logic [31:0] wdata  = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    always #5 clk = ~clk;

    muldiv_seq #(.WIDTH(32), .CNT_W(5)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .rs     (rs),
        .rt     (rt),
        .cancel (cancel),
        .mthi   (mthi),
        .mtlo   (mtlo),
        .wdata  (wdata),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    res_t        exp_q[$];
    res_t        mon_e;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] m_hi  = '0;
    logic [31:0] m_lo  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; signed divide truncates toward zero.
    function automatic res_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (o == OP_MULTU) begin
            p = {32'd0, a} * {32'd0, b};
        end else if (o == OP_MULT) begin
            p = 64'(sa * sb);
        end else if (b == 32'd0) begin
            p = {a, 32'hFFFF_FFFF};
        end else if (o == OP_DIVU) begin
            p = {a % b, a / b};
        end else begin
            q = sa / sb;
            r = sa % sb;
            p = {r[31:0], q[31:0]};
        end
        return res_t'(p);
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 50));
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 expected no result pending (hi=%h lo=%h)", hi, lo);
            end else begin
                mon_e = exp_q.pop_front();
                check("result_hi", hi, mon_e.hi);
                check("result_lo", lo, mon_e.lo);
                m_hi = mon_e.hi;
                m_lo = mon_e.lo;
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at the negedge where done is seen.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit noise);
        int k;
        int bad;
        exp_q.push_back(model(o, a, b));
        start = 1'b1;
        op    = o;
        rs    = a;
        rt    = b;
        @(negedge clk);
        start = 1'b0;
        rs    = $urandom;
        rt    = $urandom;
        check("busy_after_start", 32'(busy), 32'd1);
        k   = 0;
        bad = 0;
        while (!done && k < 100) begin
            if (!busy) bad++;
            if (noise) begin
                start = 1'b1;
                mthi  = 1'b1;
                mtlo  = 1'b1;
                wdata = $urandom;
                op    = 2'($urandom);
                rs    = $urandom;
                rt    = $urandom;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        check("latency", 32'(k), 32'd33);
        check("busy_window", 32'(bad), 32'd0);
        check("busy_at_done", 32'(busy), 32'd0);
    endtask

    task automatic cancel_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                             input int wait_n, input bit with_move);
        start = 1'b1;
        op    = o;
        rs    = a;
        rt    = b;
        if (with_move) begin
            mthi  = 1'b1;
            mtlo  = 1'b1;
            wdata = 32'hDEAD_BEEF;
        end
        @(negedge clk);
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        repeat (wait_n) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_busy", 32'(busy), 32'd0);
        check("cancel_done", 32'(done), 32'd0);
        check("cancel_hi", hi, m_hi);
        check("cancel_lo", lo, m_lo);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
        check("multu_max_hi", hi, 32'hFFFF_FFFE);
        check("multu_max_lo", lo, 32'h0000_0001);

        run_op(OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 1'b0);
        run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op(OP_DIVU,  32'd100,       32'd7,         1'b0);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         1'b0);
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(OP_DIVU,  32'd5,         32'd0,         1'b0);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd0,         1'b0);

        mthi  = 1'b1;
        wdata = 32'h1234_5678;
        @(negedge clk);
        mthi  = 1'b0;
        m_hi  = 32'h1234_5678;
        check("mthi_write", hi, 32'h1234_5678);
        mtlo  = 1'b1;
        wdata = 32'hCAFE_0001;
        @(negedge clk);
        mtlo  = 1'b0;
        m_lo  = 32'hCAFE_0001;
        check("mtlo_write", lo, 32'hCAFE_0001);

        cancel_op(OP_DIVU, 32'd9, 32'd4, 10, 1'b0);
        run_op(OP_DIVU, 32'd9, 32'd4, 1'b0);
        cancel_op(OP_MULT, $urandom, $urandom, 32, 1'b0);
        cancel_op(OP_DIV, 32'd1, 32'd1, 3, 1'b1);
        run_op(OP_MULT, $urandom, $urandom, 1'b1);

        start = 1'b1;
        op    = OP_MULT;
        rs    = $urandom;
        rt    = $urandom;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        check("midreset_hi", hi, 32'd0);
        check("midreset_lo", lo, 32'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 30; i++) begin
            run_op(2'($urandom_range(0, 3)), pick(), pick(), 1'b0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative 32-bit multiply/divide sequencer for the CPU's HI/LO unit. It executes MULT, MULTU, DIV and DIVU by driving one shared 33-bit add/subtract datapath for 32 iterations, then applies sign correction. It holds the architectural HI/LO registers and serves MTHI and MTLO. The decode/stall logic sits beside it: it issues start and stalls MFHI/MFLO while busy is high.

## Interface

- WIDTH, 32: operand width. Only 32 is supported; the parameter exists for the iteration-counter width.
- CNT_W, 5: iteration-counter width, equal to log2(WIDTH).
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  issue an operation. Sampled only in IDLE.
- op  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- rs  in  32  multiplicand or dividend.
- rt  in  32  multiplier or divisor.
- cancel  in  1  abort the operation in flight (exception flush).
- mthi  in  1  write wdata to HI.
- mtlo  in  1  write wdata to LO.
- wdata  in  32  data for mthi/mtlo.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse when HI/LO take a result.
- hi  out  32  HI register.
- lo  out  32  LO register.

## Operation

- **States:** IDLE, RUN, FIX.
- **IDLE + start:**
  - Latch op.
  - Latch |rs| and |rt| for signed ops; latch rs and rt raw for unsigned ops.
  - Latch the result-sign flags and the divisor-zero flag.
  - Clear the working accumulator and set count=0. Go to RUN.
- **RUN, multiply:** shift-add, one multiplier bit per cycle, over a 64-bit accumulator.
- **RUN, divide:** restoring divide, one quotient bit per cycle, 33-bit trial subtract.
- **RUN exit:** after count reaches 31, go to FIX.
- **FIX:**
  - Signed multiply: negate the 64-bit product if sign(rs) XOR sign(rt).
  - Signed divide: negate the quotient if the signs differ; the remainder takes the sign of rs.
  - Write HI = product[63:32] or remainder; LO = product[31:0] or quotient.
  - Pulse done. Go to IDLE.
- **Divisor zero (DIV or DIVU):** HI=rs, LO=32'hFFFFFFFF. No exception.
- **DIV 0x80000000 / 0xFFFFFFFF:** LO=0x80000000, HI=0. This is the natural result of the datapath, with no special case.
- **cancel:** in RUN or FIX, go to IDLE at the next edge. HI/LO unchanged, no done. Ignored in IDLE.
- **mthi/mtlo:** honored only in IDLE with start low; the write takes effect at the next edge. Ignored while busy.
- **IDLE, start together with mthi/mtlo:** start wins and the move is dropped.
- **start while busy:** ignored. The issuer must hold the instruction until busy is low.

## Timing

- Reset values: state IDLE, busy=0, done=0, hi=0, lo=0, internal registers 0.
- Edge E0 samples start in IDLE: busy=1 after E0.
- Edges E1..E32 perform the 32 iterations; RUN→FIX at E32.
- Edge E33 (FIX): hi/lo update, done=1 for the cycle after E33, busy=0 after E33.
- Latency is 33 cycles from the start edge to hi/lo valid.
- A new start is accepted on the edge after E33 (back-to-back throughput of 34 cycles).
- cancel and the FIX edge together: cancel wins, no write.
- Reset mid-operation: immediate return to the reset values. A partial result is never written.
- busy and done are registered outputs. hi and lo come directly from registers.

## Structure

- muldiv_pkg holds:
  - the op encodings (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV);
  - the state enum (ST_IDLE, ST_RUN, ST_FIX);
  - the ITER=32 constant.
- Sub-module addsub33: a 33-bit adder/subtractor with a sub control (a+b or a−b, carry/borrow out). It is shared by the multiply add and the divide trial subtract, with exactly one instance.
- The FIX-stage negation reuses a combinational two's-complement in the top level.

## Test plan

- Reset, then MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; done exactly 33 cycles after the start edge; busy high 33 cycles.
- MULT −3 × 7 (0xFFFFFFFD, 0x7) → hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000 × 0x80000000 → hi=0x40000000, lo=0.
- DIVU 100 / 7 → lo=14, hi=2. DIV −7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0. DIVU 5 / 0 → hi=5, lo=0xFFFFFFFF.
- MTHI 0x12345678, then DIVU 9/4 with cancel asserted at iteration 10 → no done, hi stays 0x12345678. A start on the next cycle is accepted and completes normally.
- During MULT, assert mthi/start repeatedly → both ignored. rst_n low at iteration 20 → busy=0, hi=lo=0 immediately, no done.
